// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: decodes Op/Funct, sequences
// fetch/decode/execute/memory/write-back and drives every mux select and load.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int STATE_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               ALU_ZERO,
  output logic [STATE_W-1:0] StateOut,
  output logic               PC_load,
  output logic               IR_load,
  output logic               MDR_load,
  output logic               A_load,
  output logic               B_load,
  output logic               ALUOut_load,
  output logic               PCWrite,
  output logic               BranchEq,
  output logic               BranchNe,
  output logic               wr,
  output logic               IorD,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               Halted,
  output logic               Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_LUI_WB   = 4'd13,
    S_HALT     = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_reg;
  state_t     dispatch;
  logic [3:0] wcnt_reg;
  logic       wait_done;

  assign wait_done = (wcnt_reg == WAIT_LAST);
  assign StateOut  = STATE_W'(state_reg);

  always_comb begin
    dispatch = S_ILLEGAL;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD, FN_SUB, FN_AND, FN_XOR: dispatch = S_EXEC_R;
          FN_NOP:                         dispatch = S_FETCH;
          FN_BREAK:                       dispatch = S_HALT;
          default:                        dispatch = S_ILLEGAL;
        endcase
      end
      OP_ADDI:        dispatch = S_EXEC_I;
      OP_LW, OP_SW:   dispatch = S_MEM_ADDR;
      OP_BEQ, OP_BNE: dispatch = S_BRANCH;
      OP_J:           dispatch = S_JUMP;
      OP_LUI:         dispatch = S_LUI_WB;
      default:        dispatch = S_ILLEGAL;
    endcase
  end

  // wcnt only advances inside a memory-wait state and is zero everywhere else.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_FETCH;
      wcnt_reg  <= 4'd0;
    end else begin
      wcnt_reg <= 4'd0;
      case (state_reg)
        S_FETCH: begin
          if (wait_done) state_reg <= S_DECODE;
          else           wcnt_reg  <= wcnt_reg + 4'd1;
        end
        S_DECODE:   state_reg <= dispatch;
        S_EXEC_R:   state_reg <= S_WB_R;
        S_EXEC_I:   state_reg <= S_WB_I;
        S_MEM_ADDR: state_reg <= (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (wait_done) state_reg <= S_MEM_WB;
          else           wcnt_reg  <= wcnt_reg + 4'd1;
        end
        S_MEM_WR: begin
          if (wait_done) state_reg <= S_FETCH;
          else           wcnt_reg  <= wcnt_reg + 4'd1;
        end
        S_HALT:     state_reg <= S_HALT;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    IR_load     = 1'b0;
    MDR_load    = 1'b0;
    A_load      = 1'b0;
    B_load      = 1'b0;
    ALUOut_load = 1'b0;
    PCWrite     = 1'b0;
    BranchEq    = 1'b0;
    BranchNe    = 1'b0;
    wr          = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    PCSource    = 2'b00;
    Halted      = 1'b0;
    Illegal     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IR_load = wait_done;
        PCWrite = wait_done;
      end
      S_DECODE: begin
        A_load      = 1'b1;
        B_load      = 1'b1;
        ALUSrcB     = 2'b11;
        ALUOut_load = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA     = 1'b1;
        ALUOut_load = 1'b1;
        case (Funct)
          FN_SUB:  ALUOp = ALU_SUB;
          FN_AND:  ALUOp = ALU_AND;
          FN_XOR:  ALUOp = ALU_XOR;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOut_load = 1'b1;
      end
      S_WB_I:   RegWrite = 1'b1;
      S_MEM_RD: begin
        IorD     = 1'b1;
        MDR_load = wait_done;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEM_WR: begin
        IorD = 1'b1;
        wr   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        BranchEq = (Op == OP_BEQ);
        BranchNe = (Op == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_LUI_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_HALT:    Halted  = 1'b1;
      S_ILLEGAL: Illegal = 1'b1;
      default:   ;
    endcase
    // Reset masks every write path immediately so an aborted access leaves no trace.
    if (Reset) begin
      IR_load     = 1'b0;
      MDR_load    = 1'b0;
      A_load      = 1'b0;
      B_load      = 1'b0;
      ALUOut_load = 1'b0;
      PCWrite     = 1'b0;
      BranchEq    = 1'b0;
      BranchNe    = 1'b0;
      wr          = 1'b0;
      RegWrite    = 1'b0;
    end
    PC_load = PCWrite | (BranchEq & ALU_ZERO) | (BranchNe & ~ALU_ZERO);
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-stream bench for mips_multicycle_ctrl at MEM_WAIT 2, 1 and 15,
// checked cycle by cycle against an instruction-timeline reference model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [7:0] state;
    logic       pc_load, ir_load, mdr_load, a_load, b_load, aluout_load;
    logic       pcwrite, beq, bne, wr, iord, regwrite, regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
    logic       halted, illegal;
  } ov_t;

  localparam int C_R = 0, C_NOP = 1, C_BRK = 2, C_ADDI = 3, C_LW = 4, C_SW = 5;
  localparam int C_BR = 6, C_J = 7, C_LUI = 8, C_ILL = 9;
  localparam int AB_NONE = -1, AB_LAST = -2, AB_WR2 = -3;

  logic       Clk = 1'b0;
  logic       rst  [3];
  logic [5:0] op_s [3];
  logic [5:0] fn_s [3];
  logic       zr   [3];
  ov_t        obs  [3];

  int total = 0;
  int bad   = 0;
  int ph_code[$];
  bit ph_last[$];

  always #5 Clk = ~Clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      logic [7:0] st;
      logic       pcl, irl, mdrl, al, bl, aol, pcw, beq, bne, wr, iord, rw, rd, asa, hlt, ill;
      logic [1:0] m2r, asb, pcs;
      logic [2:0] aop;
      mips_multicycle_ctrl #(
        .MEM_WAIT((gi == 0) ? 2 : ((gi == 1) ? 1 : 15)),
        .STATE_W (8)
      ) u_dut (
        .Clk(Clk), .Reset(rst[gi]), .Op(op_s[gi]), .Funct(fn_s[gi]), .ALU_ZERO(zr[gi]),
        .StateOut(st), .PC_load(pcl), .IR_load(irl), .MDR_load(mdrl), .A_load(al),
        .B_load(bl), .ALUOut_load(aol), .PCWrite(pcw), .BranchEq(beq), .BranchNe(bne),
        .wr(wr), .IorD(iord), .RegWrite(rw), .RegDst(rd), .MemtoReg(m2r), .ALUSrcA(asa),
        .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .Halted(hlt), .Illegal(ill)
      );
      assign obs[gi] = {st, pcl, irl, mdrl, al, bl, aol, pcw, beq, bne, wr, iord, rw, rd,
                        m2r, asa, asb, aop, pcs, hlt, ill};
    end
  endgenerate

  function automatic int mw(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  task automatic chk(string tag, ov_t got, ov_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int cls(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h22, 6'h24, 6'h26}) return C_R;
      if (fn == 6'h00) return C_NOP;
      if (fn == 6'h0D) return C_BRK;
      return C_ILL;
    end
    case (op)
      6'h08:        return C_ADDI;
      6'h23:        return C_LW;
      6'h2B:        return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02:        return C_J;
      6'h0F:        return C_LUI;
      default:      return C_ILL;
    endcase
  endfunction

  task automatic push_n(int code, int n);
    for (int j = 0; j < n; j++) begin
      ph_code.push_back(code);
      ph_last.push_back(j == n - 1);
    end
  endtask

  // Expected per-cycle phase timeline for one instruction.
  task automatic build(logic [5:0] op, logic [5:0] fn, int m);
    ph_code.delete();
    ph_last.delete();
    push_n(0, m + 1);
    push_n(2, 1);
    case (cls(op, fn))
      C_R:    begin push_n(3, 1); push_n(4, 1); end
      C_ADDI: begin push_n(5, 1); push_n(6, 1); end
      C_LW:   begin push_n(7, 1); push_n(8, m + 1); push_n(9, 1); end
      C_SW:   begin push_n(7, 1); push_n(10, m + 1); end
      C_BR:   push_n(11, 1);
      C_J:    push_n(12, 1);
      C_LUI:  push_n(13, 1);
      C_BRK:  push_n(14, 21);
      C_ILL:  push_n(15, 1);
      default: ;
    endcase
  endtask

  function automatic ov_t expect_out(int code, bit last, bit r, logic [5:0] op,
                                     logic [5:0] fn, bit z);
    ov_t e;
    e = '0;
    e.state = 8'(code);
    case (code)
      0:  begin e.alusrcb = 2'b01; e.ir_load = last; e.pcwrite = last; end
      2:  begin e.a_load = 1; e.b_load = 1; e.alusrcb = 2'b11; e.aluout_load = 1; end
      3: begin
        e.alusrca = 1; e.aluout_load = 1;
        e.aluop = (fn == 6'h22) ? 3'd1 : (fn == 6'h24) ? 3'd2 : (fn == 6'h26) ? 3'd3 : 3'd0;
      end
      4:  begin e.regwrite = 1; e.regdst = 1; end
      5, 7: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluout_load = 1; end
      6:  e.regwrite = 1;
      8:  begin e.iord = 1; e.mdr_load = last; end
      9:  begin e.regwrite = 1; e.memtoreg = 2'b01; end
      10: begin e.iord = 1; e.wr = 1; end
      11: begin
        e.alusrca = 1; e.aluop = 3'd1; e.pcsource = 2'b01;
        e.beq = (op == 6'h04); e.bne = (op == 6'h05);
      end
      12: begin e.pcwrite = 1; e.pcsource = 2'b10; end
      13: begin e.regwrite = 1; e.memtoreg = 2'b10; end
      14: e.halted = 1;
      15: e.illegal = 1;
      default: ;
    endcase
    // PC is written at end of fetch, on a jump, or on a taken branch.
    e.pc_load = (code == 0 && last) || code == 12 ||
                (code == 11 && ((op == 6'h04 && z) || (op == 6'h05 && !z)));
    if (r) begin
      e.pc_load = 0; e.ir_load = 0; e.mdr_load = 0; e.a_load = 0; e.b_load = 0;
      e.aluout_load = 0; e.pcwrite = 0; e.beq = 0; e.bne = 0; e.wr = 0; e.regwrite = 0;
    end
    return e;
  endfunction

  int n_instr = 0;

  task automatic exec_instr(int d, logic [5:0] op, logic [5:0] fn, int zmode, int abort);
    int ai;
    int ncyc;
    build(op, fn, mw(d));
    ai = abort;
    if (abort == AB_LAST) ai = ph_code.size() - 1;
    if (abort == AB_WR2) begin
      ai = AB_NONE;
      for (int i = 0; i < ph_code.size(); i++)
        if (ph_code[i] == 10 && ai == AB_NONE) ai = i + 1;
    end
    op_s[d] = op;
    fn_s[d] = fn;
    ncyc = 0;
    for (int i = 0; i < ph_code.size(); i++) begin
      bit z;
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zr[d] = z;
      if (i == ai) rst[d] = 1'b1;
      #1;
      chk($sformatf("d%0d n%0d c%0d", d, n_instr, i), obs[d],
          expect_out(ph_code[i], ph_last[i], i == ai, op, fn, z));
      @(posedge Clk);
      #1;
      ncyc++;
      if (i == ai) begin
        rst[d] = 1'b0;
        break;
      end
    end
    $display("instr n=%0d dut=%0d mem_wait=%0d op=%02h funct=%02h cycles=%0d%s", n_instr, d,
             mw(d), op, fn, ncyc, (ai >= 0) ? " reset" : "");
    n_instr++;
  endtask

  task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = $urandom_range(0, 12);
    op = 6'h00;
    fn = 6'($urandom);
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h26;
      4: fn = 6'h00;
      5: op = 6'h08;
      6: op = 6'h23;
      7: op = 6'h2B;
      8: op = 6'h04;
      9: op = 6'h05;
      10: op = 6'h02;
      11: op = 6'h0F;
      default: begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (cls(op, fn) != C_ILL);
      end
    endcase
  endtask

  task automatic do_reset(int d);
    rst[d] = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk($sformatf("d%0d reset", d), obs[d], expect_out(0, 1'b0, 1'b1, 6'h00, 6'h00, zr[d]));
    rst[d] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] rop, rfn;
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      op_s[i] = 6'h00;
      fn_s[i] = 6'h00;
      zr[i]   = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      do_reset(d);
      if (d == 0) begin
        exec_instr(d, 6'h00, 6'h20, -1, AB_NONE);
        exec_instr(d, 6'h23, 6'h11, -1, AB_NONE);
        exec_instr(d, 6'h2B, 6'h05, -1, AB_NONE);
        exec_instr(d, 6'h04, 6'h00, 1, AB_NONE);
        exec_instr(d, 6'h04, 6'h00, 0, AB_NONE);
        exec_instr(d, 6'h05, 6'h00, 0, AB_NONE);
        exec_instr(d, 6'h05, 6'h00, 1, AB_NONE);
        exec_instr(d, 6'h02, 6'h3F, -1, AB_NONE);
        exec_instr(d, 6'h0F, 6'h00, -1, AB_NONE);
        exec_instr(d, 6'h00, 6'h00, -1, AB_NONE);
        exec_instr(d, 6'h08, 6'h2A, -1, AB_NONE);
        exec_instr(d, 6'h3F, 6'h20, -1, AB_NONE);
        exec_instr(d, 6'h00, 6'h01, -1, AB_NONE);
        for (int k = 0; k < 40; k++) begin
          rand_instr(rop, rfn);
          exec_instr(d, rop, rfn, -1, AB_NONE);
        end
        exec_instr(d, 6'h00, 6'h0D, -1, AB_LAST);
        exec_instr(d, 6'h00, 6'h22, -1, AB_NONE);
      end
      exec_instr(d, 6'h2B, 6'h00, -1, AB_WR2);
      exec_instr(d, 6'h00, 6'h26, -1, AB_NONE);
      exec_instr(d, 6'h23, 6'h00, -1, AB_NONE);
      for (int k = 0; k < 8; k++) begin
        rand_instr(rop, rfn);
        exec_instr(d, rop, rfn, -1, AB_NONE);
      end
      rst[d] = 1'b1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Parametrised main control FSM for the multicycle MIPS datapath. It decodes `Op` and `Funct` internally and drives every datapath mux select and register load, including `PC_load`. Memory wait states are set by a parameter, so fixed wait states are no longer hard-coded. It adds ADDI, in-FSM R-type decode, BNE, sticky BREAK halt and illegal-instruction signalling, and sits between the instruction register and the datapath.

## Interface
- `MEM_WAIT`, 2: wait cycles after each memory access issue; legal range is 1 to 15.
- `STATE_W`, 8: width of `StateOut`; must be at least 4.
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Op` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `ALU_ZERO` in 1: ALU result equals zero.
- `StateOut` out STATE_W: current state code, zero-extended.
- `PC_load`, `IR_load`, `MDR_load`, `A_load`, `B_load`, `ALUOut_load` out 1 each: register loads.
- `PCWrite`, `BranchEq`, `BranchNe` out 1 each: PC write sources.
- `wr` out 1: 1 = memory write.
- `IorD` out 1: 1 = memory address comes from ALUOut.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MemtoReg` out 2: write-back source; 00 = ALUOut, 01 = MDR, 10 = {imm,16'b0}.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `ALUOp` out 3: 000 add, 001 sub, 010 and, 011 xor.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Halted` out 1: BREAK executed.
- `Illegal` out 1: unsupported instruction decoded.

## Operation
- State codes:
  - FETCH 0, DECODE 2, EXEC_R 3, WB_R 4, EXEC_I 5, WB_I 6, MEM_ADDR 7, MEM_RD 8, MEM_WB 9, MEM_WR 10.
  - BRANCH 11, JUMP 12, LUI_WB 13, HALT 14, ILLEGAL 15.
- Outputs are Moore decode of the state. Every output not listed for a state is 0; no x values are driven.
- PC load: `PC_load = PCWrite | (BranchEq & ALU_ZERO) | (BranchNe & ~ALU_ZERO)`.
- A wait counter `wcnt` counts 0..MEM_WAIT in FETCH, MEM_RD and MEM_WR; the state exits when `wcnt == MEM_WAIT`.
- FETCH:
  - All cycles: IorD=0, wr=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - Final cycle only: IR_load=1, PCWrite=1.
  - Next state: DECODE.
- DECODE: A_load=1, B_load=1, ALUSrcA=0, ALUSrcB=11, ALUOp=add, ALUOut_load=1 (branch target). Dispatch:
  - Op 0x00, Funct 0x20/0x22/0x24/0x26 → EXEC_R.
  - Op 0x00, Funct 0x00 → FETCH (NOP).
  - Op 0x00, Funct 0x0D → HALT.
  - Op 0x08 → EXEC_I.
  - Op 0x23 or 0x2B → MEM_ADDR.
  - Op 0x04 or 0x05 → BRANCH.
  - Op 0x02 → JUMP.
  - Op 0x0F → LUI_WB.
  - Anything else → ILLEGAL.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp from funct (add/sub/and/xor), ALUOut_load=1. Next: WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=00. Next: FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=add, ALUOut_load=1. Next: WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=00. Next: FETCH.
- MEM_ADDR: same datapath controls as EXEC_I. Next: MEM_RD if Op=0x23, MEM_WR if Op=0x2B.
- MEM_RD: IorD=1, wr=0 for the whole state; MDR_load=1 in the final cycle. Next: MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=01. Next: FETCH.
- MEM_WR: IorD=1, wr=1 for the whole state. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01. BranchEq=1 if Op=0x04; BranchNe=1 if Op=0x05. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- LUI_WB: RegWrite=1, RegDst=0, MemtoReg=10. Next: FETCH.
- HALT: Halted=1; all enables 0. Self-loop until Reset.
- ILLEGAL: Illegal=1 for exactly one cycle; no architectural writes. Next: FETCH.
- `Op`/`Funct` are sampled only in DECODE, EXEC_R, MEM_ADDR and BRANCH. The IR is stable in all of these.

## Timing
- Reset:
  - A rising edge with Reset=1 sets state=FETCH and wcnt=0, and clears Halted.
  - While Reset=1, all load and write enables are forced to 0 combinationally, including PC_load, RegWrite and wr.
  - Reset mid-wait (any state) aborts the access. The first post-reset FETCH cycle follows.
- Cycles per instruction (M = MEM_WAIT):
  - R-type and ADDI: M+4.
  - LW: 2M+5.
  - SW: 2M+4.
  - BEQ, BNE, J, LUI: M+3.
  - NOP: M+2.
  - Illegal: M+3.
- `PC_load` in BRANCH is combinational on ALU_ZERO within the same cycle.
- ALU_ZERO is ignored in all other states.
- `wcnt` returns to 0 on every state exit and never exceeds MEM_WAIT.

## Test plan
- MEM_WAIT=2, ADD (Op 0, Funct 0x20):
  - StateOut sequence 0,0,0,2,3,4,0.
  - IR_load and PCWrite high only in the 3rd cycle.
  - RegWrite=1, RegDst=1 in state 4.
- MEM_WAIT=2, LW then SW:
  - LW: 9 cycles; MDR_load pulses once, in the 3rd MEM_RD cycle; MEM_WB has MemtoReg=01.
  - SW: 8 cycles; wr=1 for exactly 3 consecutive cycles.
- BEQ with ALU_ZERO=1 then 0: PC_load=1 then 0 in BRANCH. BNE with ALU_ZERO=0: PC_load=1. PCSource=01 in all cases.
- Op 0x3F → ILLEGAL: Illegal pulses 1 cycle, then back to FETCH; RegWrite, wr and PC_load never asserted.
- BREAK (Funct 0x0D) → Halted=1 for 20 cycles with StateOut=14 and all enables 0. Reset for 1 edge → FETCH and Halted=0.
- Reset asserted in the 2nd MEM_WR cycle: wr drops the same cycle; the next state is FETCH with wcnt=0. Repeat with MEM_WAIT=1 and MEM_WAIT=15.
